cim_core_acc_array: RTL

//  Parametrised successor of the fixed 3x3 CIM core: a ROWS x COLS array of Macro instances with a horizontal activation pipeline.

---
 rtl/cim_core_acc_array.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/cim_core_acc_array.sv
// cim_core_acc_array: ROWS x COLS CIM macro array, skewed activation pipe,
// per-macro multi-pass PSUM accumulation, output deskew, guarded weight port.
// Ports: clk, rst_n (sync, active low); in_valid/in_last/act_in beat input;
//   STDW/STDR/STD_A/weight_in/weight_out weight port; busy, std_rej;
//   out_valid/psum_out deskewed group results (ACC_W each, saturating).
// Build option: CIM_ACT_HOLD_EN holds act_p[c>=1] on idle beats.

module cim_macro #(
    parameter int N_ACT  = 64,
    parameter int ACT_W  = 4,
    parameter int N_OUT  = 8,
    parameter int PSUM_W = 14,
    parameter int ADDR_W = 6
) (
    input  logic                      clk,
    input  logic [N_ACT*ACT_W-1:0]    i_act,
    input  logic                      i_stdw,
    input  logic                      i_stdr,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [N_OUT*ACT_W-1:0]    i_wdata,
    output logic [N_OUT*ACT_W-1:0]    o_rdata,
    output logic [N_OUT*PSUM_W-1:0]   o_psum
);
    // Row i holds the N_OUT weights applied to activation i.
    logic [N_OUT*ACT_W-1:0] r_mem [2**ADDR_W];
    logic signed [2*ACT_W-1:0] w_prod;
    logic signed [PSUM_W-1:0] w_acc;

    always_ff @(posedge clk) begin
        if (i_stdw) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = i_stdr ? r_mem[i_addr] : '0;

    always_comb begin
        o_psum = '0;
        w_prod = '0;
        w_acc  = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_acc = '0;
            for (int i = 0; i < N_ACT; i++) begin
                w_prod = $signed(i_act[i*ACT_W +: ACT_W])
                       * $signed(r_mem[ADDR_W'(i)][j*ACT_W +: ACT_W]);
                w_acc = w_acc
                      + {{(PSUM_W-2*ACT_W){w_prod[2*ACT_W-1]}}, w_prod};
            end
            o_psum[j*PSUM_W +: PSUM_W] = w_acc;
        end
    end
endmodule

module cim_core_acc_array #(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int N_ACT  = 64,
    parameter int ACT_W  = 4,
    parameter int N_OUT  = 8,
    parameter int PSUM_W = 14,
    parameter int ACC_W  = 20,
    parameter int ADDR_W = 6
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic                               in_last,
    input  logic [ROWS*N_ACT*ACT_W-1:0]        act_in,
    input  logic                               STDW,
    input  logic                               STDR,
    input  logic [ADDR_W-1:0]                  STD_A,
    input  logic [ROWS*COLS*N_OUT*ACT_W-1:0]   weight_in,
    output logic [ROWS*COLS*N_OUT*ACT_W-1:0]   weight_out,
    output logic                               busy,
    output logic                               std_rej,
    output logic                               out_valid,
    output logic [ROWS*COLS*N_OUT*ACC_W-1:0]   psum_out
);
    localparam int AW = ROWS*N_ACT*ACT_W;
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [AW-1:0]   w_act_p [COLS];
    logic [AW-1:0]   r_act_p [COLS-1];
    logic [COLS-1:0] w_v_p;
    logic [COLS-1:0] w_l_p;
    logic [COLS-2:0] r_v_p;
    logic [COLS-2:0] r_l_p;
    logic [COLS-1:0] r_first;
    logic            r_out_valid;
    logic            r_std_rej;
    logic            w_busy;
    logic            w_stdw;

    assign w_act_p[0] = act_in;
    assign w_v_p[0]   = in_valid;
    assign w_l_p[0]   = in_last & in_valid;

    for (genvar c = 1; c < COLS; c++) begin : g_pipe
        assign w_act_p[c] = r_act_p[c-1];
        assign w_v_p[c]   = r_v_p[c-1];
        assign w_l_p[c]   = r_l_p[c-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v_p <= '0;
            r_l_p <= '0;
            for (int c = 0; c < COLS-1; c++) r_act_p[c] <= '0;
        end else begin
            r_v_p <= w_v_p[COLS-2:0];
            r_l_p <= w_l_p[COLS-2:0];
            for (int c = 0; c < COLS-1; c++) begin
`ifdef CIM_ACT_HOLD_EN
                if (w_v_p[c]) r_act_p[c] <= w_act_p[c];
`else
                r_act_p[c] <= w_act_p[c];
`endif
            end
        end
    end

    // A processed beat leaves first set exactly when it closed its group.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_first <= '1;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (w_v_p[c]) r_first[c] <= w_l_p[c];
            end
        end
    end

    assign w_busy = in_valid | (|r_v_p) | ~(&r_first);
    assign w_stdw = STDW & ~w_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_std_rej   <= 1'b0;
        end else begin
            r_out_valid <= w_l_p[COLS-1];
            r_std_rej   <= STDW & w_busy;
        end
    end

    assign busy      = w_busy;
    assign std_rej   = r_std_rej;
    assign out_valid = r_out_valid;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int K = r*COLS + c;
            localparam int D = COLS - 1 - c;
            logic [N_OUT*PSUM_W-1:0] w_psum;
            logic [N_OUT*ACC_W-1:0]  r_acc;
            logic [N_OUT*ACC_W-1:0]  r_res;
            logic [N_OUT*ACC_W-1:0]  w_sum;
            logic [ACC_W-1:0]        w_base;
            logic [PSUM_W-1:0]       w_ps;
            logic [ACC_W:0]          w_wide;

            cim_macro #(
                .N_ACT(N_ACT), .ACT_W(ACT_W), .N_OUT(N_OUT),
                .PSUM_W(PSUM_W), .ADDR_W(ADDR_W)
            ) u_mac (
                .clk     (clk),
                .i_act   (w_act_p[c][r*N_ACT*ACT_W +: N_ACT*ACT_W]),
                .i_stdw  (w_stdw),
                .i_stdr  (STDR),
                .i_addr  (STD_A),
                .i_wdata (weight_in[K*N_OUT*ACT_W +: N_OUT*ACT_W]),
                .o_rdata (weight_out[K*N_OUT*ACT_W +: N_OUT*ACT_W]),
                .o_psum  (w_psum)
            );

            // One guard bit; a sign mismatch against bit ACC_W-1 is overflow.
            always_comb begin
                w_sum  = '0;
                w_base = '0;
                w_ps   = '0;
                w_wide = '0;
                for (int j = 0; j < N_OUT; j++) begin
                    w_base = r_first[c] ? '0 : r_acc[j*ACC_W +: ACC_W];
                    w_ps   = w_psum[j*PSUM_W +: PSUM_W];
                    w_wide = {w_base[ACC_W-1], w_base}
                           + {{(ACC_W+1-PSUM_W){w_ps[PSUM_W-1]}}, w_ps};
                    if (w_wide[ACC_W] != w_wide[ACC_W-1])
                        w_sum[j*ACC_W +: ACC_W] = w_wide[ACC_W] ? SMIN : SMAX;
                    else
                        w_sum[j*ACC_W +: ACC_W] = w_wide[ACC_W-1:0];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_acc <= '0;
                    r_res <= '0;
                end else if (w_v_p[c]) begin
                    if (w_l_p[c]) r_res <= w_sum;
                    else          r_acc <= w_sum;
                end
            end

            // Earlier columns finish earlier; delay them to line up.
            if (D == 0) begin : g_nodsk
                assign psum_out[K*N_OUT*ACC_W +: N_OUT*ACC_W] = r_res;
            end else begin : g_dsk
                logic [N_OUT*ACC_W-1:0] r_dsk [D];
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        for (int d = 0; d < D; d++) r_dsk[d] <= '0;
                    end else begin
                        r_dsk[0] <= r_res;
                        for (int d = 1; d < D; d++) r_dsk[d] <= r_dsk[d-1];
                    end
                end
                assign psum_out[K*N_OUT*ACC_W +: N_OUT*ACC_W] = r_dsk[D-1];
            end
        end
    end
endmodule
